// File: rtl/sub_8bit_serial_pkg.sv
// Shared constants and FSM state type for the bit-serial 8-bit subtractor.
package sub_pkg;

  localparam int WIDTH     = 8;
  localparam int CNT_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub_8bit_serial_full_subtractor.sv
// Combinational 1-bit full subtractor: d = x - y - bin, bout is the borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/sub_8bit_serial.sv
// Bit-serial 8-bit subtractor: one bit per clock, LSB first, result {borrow, diff}.
// Optional signed-overflow output is enabled by defining SUB_OVF_EN.
module sub_8bit_serial
  import sub_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
`ifdef SUB_OVF_EN
  output logic             ovf,
`endif
  output logic [WIDTH:0]   out
);

  state_t               state;
  logic [WIDTH-1:0]     a_sr;
  logic [WIDTH-1:0]     b_sr;
  logic [WIDTH-1:0]     diff_sr;
  logic                 borrow;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 d_bit;
  logic                 bout_bit;
  logic                 last_bit;

  full_subtractor u_fs (
    .x   (a_sr[0]),
    .y   (b_sr[0]),
    .bin (borrow),
    .d   (d_bit),
    .bout(bout_bit)
  );

  assign last_bit = (cnt == CNT_WIDTH'(WIDTH - 1));
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples the pre-edge values of the others, as the hardware does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      borrow  <= 1'b0;
      cnt     <= '0;
      out     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= 1'b0;
            cnt    <= '0;
            state  <= RUN;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          borrow  <= bout_bit;
          diff_sr <= {d_bit, diff_sr[WIDTH-1:1]};
          cnt     <= cnt + 1'b1;
          if (last_bit) begin
            // Final bit goes straight into out; diff_sr still holds bits 0..6.
            out   <= {bout_bit, d_bit, diff_sr[WIDTH-1:1]};
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SUB_OVF_EN
  // On the last bit, a_sr[0]/b_sr[0] are the operand sign bits and d_bit is
  // the result sign bit, so no extra copy of the operands is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (state == RUN && last_bit) begin
      ovf <= (a_sr[0] != b_sr[0]) && (d_bit != a_sr[0]);
    end
  end
`endif

endmodule
